// File: rtl/nn_pkg.sv
// Shared types and arithmetic helpers for the fully-connected layer datapath.
package nn_pkg;

  typedef enum logic [1:0] {
    ACT_LIN  = 2'd0,
    ACT_RELU = 2'd1,
    ACT_STEP = 2'd2
  } act_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    ACT  = 2'd2,
    DONE = 2'd3
  } fc_state_t;

  // Arithmetic right shift followed by saturation to a dw-bit signed range.
  // Operates at a fixed 64-bit width; callers sign-extend in and truncate out.
  function automatic logic signed [31:0] sat_shift(input logic signed [63:0] acc,
                                                   input int shift,
                                                   input int dw);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = acc >>> shift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return 32'(s);
  endfunction

endpackage

// File: rtl/nn_fc_layer_if.sv
// Bus bundle for the FC layer: weight write port, input vector, result vector.
interface nn_fc_layer_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int DW    = 8,
  parameter int WW    = 8
);
  localparam int AW = $clog2(N_OUT * (N_IN + 1));

  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic signed [WW-1:0]    wr_data;
  logic                    wr_err;
  logic [1:0]              act_mode;
  logic                    in_valid;
  logic                    in_ready;
  logic [N_IN*DW-1:0]      in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_OUT*DW-1:0]     out_data;
  logic                    busy;

  modport master (
    output wr_en, wr_addr, wr_data, act_mode, in_valid, in_data, out_ready,
    input  wr_err, in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, act_mode, in_valid, in_data, out_ready,
    output wr_err, in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/nn_mac_unit.sv
// Single multiply-accumulate lane with bias preload and output activation.
module nn_mac_unit
  import nn_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic signed [WW-1:0] bias_i,
  input  logic                 mac_i,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [WW-1:0] w_i,
  input  logic [1:0]           mode_i,
  output logic signed [DW-1:0] res_o
);
  localparam int PW   = DW + WW;
  localparam int ACCW = DW + WW + $clog2(N_IN + 1);

  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [PW-1:0]   prod;
  logic signed [DW-1:0]   sat;

  // Full-precision signed product of the current input element and weight.
  always_comb begin
    prod = PW'(x_i) * PW'(w_i);
  end

  // Bias preload takes priority; otherwise accumulate while the FSM is in MAC.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = ACCW'(bias_i);
    end else if (mac_i) begin
      acc_d = acc_q + ACCW'(prod);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Activation; step looks at the raw accumulator, the others at the saturated value.
  always_comb begin
    sat = DW'(sat_shift(64'(acc_q), SHIFT, DW));
    case (mode_i)
      ACT_RELU: res_o = sat[DW-1] ? '0 : sat;
      ACT_STEP: res_o = (!acc_q[ACCW-1] && (acc_q != '0)) ? DW'(1) : '0;
      default:  res_o = sat;
    endcase
  end

endmodule

// File: rtl/nn_fc_layer.sv
// FC layer top: sequencing FSM, counters, weight register file and handshakes.
//
// state | meaning
// IDLE  | waiting for an input vector, weight writes accepted
// MAC   | accumulating x[i]*w[j][i] for neuron j
// ACT   | activation of neuron j written to its output slot
// DONE  | result vector presented until out_ready
module nn_fc_layer
  import nn_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int SHIFT = 0
) (
  input  logic          clk,
  input  logic          rst,
  nn_fc_layer_if.slave  bus
);
  localparam int NW = N_OUT * (N_IN + 1);
  localparam int AW = $clog2(NW);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  fc_state_t            state_q, state_d;
  logic [IW-1:0]        i_q, i_d;
  logic [JW-1:0]        j_q, j_d;
  logic signed [DW-1:0] x_q   [N_IN];
  logic [1:0]           mode_q;
  logic signed [WW-1:0] w_q   [NW];
  logic signed [DW-1:0] res_q [N_OUT];
  logic                 wr_err_q;

  logic                 accept;
  logic                 wr_ok;
  logic                 load;
  logic                 mac_en;
  logic [AW-1:0]        b_addr;
  logic [AW-1:0]        w_addr;
  logic signed [WW-1:0] bias_sel;
  logic signed [DW-1:0] act_res;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign wr_ok  = bus.wr_en && (state_q == IDLE) && (bus.wr_addr < AW'(NW));
  assign w_addr = AW'(int'(j_q) * (N_IN + 1) + int'(i_q));
  // A write landing on the bias being preloaded this edge is forwarded, so an
  // inference accepted together with that write already sees the new bias.
  assign bias_sel = (wr_ok && (bus.wr_addr == b_addr)) ? bus.wr_data : w_q[b_addr];
  assign bus.wr_err = wr_err_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = MAC;
      MAC:  if (i_q == IW'(N_IN - 1)) state_d = ACT;
      ACT:  state_d = (j_q != JW'(N_OUT - 1)) ? MAC : DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshakes, status and MAC-unit controls.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b1;
    bus.out_valid = 1'b0;
    mac_en        = 1'b0;
    load          = 1'b0;
    b_addr        = AW'(N_IN);
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        load         = accept;
      end
      MAC: mac_en = 1'b1;
      ACT: begin
        if (j_q != JW'(N_OUT - 1)) begin
          load   = 1'b1;
          b_addr = AW'((int'(j_q) + 1) * (N_IN + 1) + N_IN);
        end
      end
      DONE: bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Element and neuron index sequencing.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          i_d = '0;
          j_d = '0;
        end
      end
      MAC: if (i_q != IW'(N_IN - 1)) i_d = i_q + 1'b1;
      ACT: begin
        if (j_q != JW'(N_OUT - 1)) begin
          j_d = j_q + 1'b1;
          i_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  // Input capture on accept and per-neuron result write-back in ACT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_IN; k++) x_q[k] <= '0;
      for (int k = 0; k < N_OUT; k++) res_q[k] <= '0;
      mode_q <= '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < N_IN; k++) x_q[k] <= bus.in_data[k*DW +: DW];
        mode_q <= bus.act_mode;
      end
      if (state_q == ACT) begin
        res_q[j_q] <= act_res;
      end
    end
  end

  // Weight/bias register file; reset clears every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else if (wr_ok) begin
      w_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Rejected-write pulse, one cycle after the offending strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= bus.wr_en && !wr_ok;
    end
  end

  // Pack neuron results onto the output bus.
  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < N_OUT; k++) bus.out_data[k*DW +: DW] = res_q[k];
  end

  nn_mac_unit #(
    .N_IN  (N_IN),
    .DW    (DW),
    .WW    (WW),
    .SHIFT (SHIFT)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .bias_i (bias_sel),
    .mac_i  (mac_en),
    .x_i    (x_q[i_q]),
    .w_i    (w_q[w_addr]),
    .mode_i (mode_q),
    .res_o  (act_res)
  );

endmodule

// File: tb/tb_nn_fc_layer.sv
// Scoreboard bench for nn_fc_layer with directed, hand-computed vectors.
module tb_nn_fc_layer;
  localparam int N_IN = 4, N_OUT = 2, DW = 8, WW = 8;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic vld_seen = 1'b0;

  typedef struct {
    logic [15:0] data;
    int          acc_cyc;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nn_fc_layer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WW(WW)) bus ();

  nn_fc_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WW(WW), .SHIFT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // neuron0 weights 1,2,3,4 bias 5; neuron1 weights -1 x4 bias 0
  task automatic load_s1();
    wr(4'd0, 8'd1); wr(4'd1, 8'd2); wr(4'd2, 8'd3); wr(4'd3, 8'd4); wr(4'd4, 8'd5);
    for (int k = 5; k < 9; k++) wr(4'(k), 8'hFF);
    wr(4'd9, 8'd0);
  endtask

  task automatic load_uniform(input logic [7:0] w);
    for (int k = 0; k < 10; k++) wr(4'(k), ((k == 4) || (k == 9)) ? 8'd0 : w);
  endtask

  task automatic start_infer(input logic [31:0] x, input logic [1:0] m,
                             input logic [15:0] e, input bit track);
    exp_t ent;
    for (int n = 0; n < 50 && !bus.in_ready; n++) tick();
    if (!bus.in_ready) begin
      tests++; fails++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    bus.act_mode = m;
    if (track) begin
      ent.data    = e;
      ent.acc_cyc = cyc + 1;
      sbq.push_back(ent);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 60 && sbq.size() != 0; n++) tick();
    if (sbq.size() != 0) begin
      tests++; fails++;
      $display("FAIL result_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Monitor: checks latency when out_valid rises and data at each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      vld_seen = 1'b0;
    end else begin
      if (bus.out_valid && !vld_seen) begin
        vld_seen = 1'b1;
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out_valid: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          chk("latency", 32'(cyc - sbq[0].acc_cyc), 32'd10);
        end
      end
      if (bus.out_valid && bus.out_ready && sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.data));
        vld_seen = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.act_mode = 2'd0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_wr_err",    32'(bus.wr_err),    32'd0);

    // linear, relu, step, reserved mode on scenario-1 data
    load_s1();
    start_infer(32'h01010101, 2'd0, 16'hFC0F, 1'b1); wait_done();
    start_infer(32'h01010101, 2'd1, 16'h000F, 1'b1); wait_done();
    start_infer(32'h01010101, 2'd2, 16'h0001, 1'b1); wait_done();
    start_infer(32'h01010101, 2'd3, 16'hFC0F, 1'b1); wait_done();

    // saturation both ways
    load_uniform(8'h7F);
    start_infer(32'h7F7F7F7F, 2'd0, 16'h7F7F, 1'b1); wait_done();
    load_uniform(8'h80);
    start_infer(32'h7F7F7F7F, 2'd0, 16'h8080, 1'b1); wait_done();

    // back-pressure: output held, in_valid ignored
    load_s1();
    bus.out_ready = 1'b0;
    start_infer(32'h01010101, 2'd0, 16'hFC0F, 1'b1);
    for (int n = 0; n < 40 && !bus.out_valid; n++) tick();
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = (k == 2);
      bus.in_data  = 32'h7F7F7F7F;
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_out_data",  32'(bus.out_data),  32'h0000FC0F);
      chk("hold_in_ready",  32'(bus.in_ready),  32'd0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_hs_pending",  32'(sbq.size()),   32'd0);

    // rejected writes: during MAC and out-of-range address in IDLE
    start_infer(32'h01010101, 2'd0, 16'hFC0F, 1'b1);
    tick();
    wr(4'd0, 8'h63);
    chk("wr_err_mac", 32'(bus.wr_err), 32'd1);
    tick();
    chk("wr_err_clear", 32'(bus.wr_err), 32'd0);
    wait_done();
    wr(4'd10, 8'h63);
    chk("wr_err_range", 32'(bus.wr_err), 32'd1);
    wr(4'd4, 8'd5);
    chk("wr_err_valid", 32'(bus.wr_err), 32'd0);
    start_infer(32'h01010101, 2'd0, 16'hFC0F, 1'b1); wait_done();

    // reset in the 3rd MAC cycle aborts and clears weights
    start_infer(32'h01010101, 2'd0, 16'h0000, 1'b0);
    tick();
    tick();
    chk("mac_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy",      32'(bus.busy),      32'd0);
    chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
    tick();
    rst = 1'b0;
    tick();
    start_infer(32'h01010101, 2'd0, 16'h0000, 1'b1); wait_done();

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nn_fc_layer.md
# nn_fc_layer

Parametrised fully-connected neural-network layer for the TinyTapeout neural-network design. It supersedes the fixed-size neuron datapath and computes N_OUT neurons over an N_IN-element signed input vector, using one time-multiplexed multiply-accumulate unit. Weights and biases are held in on-chip registers loaded through a write port. Inputs and results move over valid/ready handshakes, and a selectable activation stage (linear-saturate, ReLU, step) sits on the output.

## Interface

Parameters:
- N_IN, 4: inputs per neuron.
- N_OUT, 2: neurons.
- DW, 8: signed input/output data width.
- WW, 8: signed weight/bias width.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.
- AW, derived $clog2(N_OUT*(N_IN+1)): weight address width.
- ACCW, derived DW+WW+$clog2(N_IN+1): accumulator width.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  weight write strobe.
- wr_addr  in  AW  address = j*(N_IN+1)+i; i=N_IN is the bias of neuron j.
- wr_data  in  WW  signed weight/bias.
- wr_err  out  1  one-cycle pulse when a write is rejected.
- act_mode  in  2  0 linear, 1 ReLU, 2 step, 3 reserved (treated as linear); sampled on input accept.
- in_valid  in  1  input vector valid.
- in_ready  out  1  high only in IDLE.
- in_data  in  N_IN*DW  element i at [i*DW +: DW], signed.
- out_valid  out  1  result vector valid.
- out_ready  in  1  consumer accepts.
- out_data  out  N_OUT*DW  neuron j at [j*DW +: DW], signed.
- busy  out  1  state != IDLE.

## Operation

- States: IDLE, MAC, ACT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - capture in_data and act_mode;
  - set j=0, i=0, acc=sign-extended bias[0];
  - go to MAC.
- MAC: acc += x[i]*w[j][i] (full-precision signed product). At i=N_IN-1, go to ACT; otherwise i++.
- ACT:
  - r = acc >>> SHIFT, saturated to [-2^(DW-1), 2^(DW-1)-1].
  - Linear: r. ReLU: max(r,0). Step: 1 if acc>0, else 0.
  - Write the result into out_data slot j. If j<N_OUT-1: j++, i=0, acc=bias[j+1], go to MAC. Otherwise go to DONE.
- DONE:
  - out_valid=1; out_data held stable.
  - On out_ready, return to IDLE at the next edge.
- Writes:
  - Accepted only in IDLE with wr_addr < N_OUT*(N_IN+1).
  - Otherwise ignored, and wr_err pulses at the next edge.
  - Writes in IDLE coincident with an input accept commit at the same edge and are used by that inference.
- Reset values:
  - All weights/biases 0, out_data 0, out_valid 0, wr_err 0, busy 0.
  - in_ready=1 (IDLE).
- Reset mid-operation aborts immediately. The partial result is discarded and weights are cleared.

## Timing

- Compute latency:
  - out_valid rises exactly N_OUT*(N_IN+1) cycles after the input-accept edge (default 10).
  - Total cycle count is N_OUT*(N_IN+1)+1, including the DONE handshake cycle.
- out_valid stays high and out_data stays constant until out_ready is sampled high. in_ready is low throughout; in_valid in non-IDLE states is ignored.
- Earliest next accept: the cycle after the output handshake (no overlap).
- wr_err: registered pulse, one cycle after the offending wr_en.
- Arithmetic:
  - Products are DW+WW bits; the accumulator is ACCW bits and never overflows for N_IN terms plus bias.
  - Saturation applies only after the shift.

## Structure

- Shared package nn_pkg holds:
  - act_mode_t enum (ACT_LIN, ACT_RELU, ACT_STEP);
  - fc_state_t enum (IDLE, MAC, ACT, DONE);
  - sat_shift() function (shift plus saturate, parametrised by widths).
- Sub-module nn_mac_unit holds the signed multiplier, accumulator register, bias load and activation/saturation logic.
- The top level holds the FSM, counters, weight register file and handshakes.

## Test plan

Defaults N_IN=4, N_OUT=2, DW=WW=8, SHIFT=0.

1. Load w0=[1,2,3,4], b0=5; w1=[-1,-1,-1,-1], b1=0; x=[1,1,1,1], linear -> out0=15, out1=-4; out_valid exactly 10 cycles after accept.
2. Same data, ReLU -> (15,0); step -> (1,0).
3. All weights and inputs 127, bias 0, linear -> both 127. Weights -128, inputs 127 -> both -128.
4. Hold out_ready low for 5 cycles after out_valid -> out_data/out_valid stable, in_ready=0, an in_valid pulse ignored. Raise out_ready -> in_ready=1 next cycle.
5. wr_en during MAC, and wr_addr=10 in IDLE -> wr_err pulses each time. The next inference reproduces scenario-1 results.
6. Assert rst during the 3rd MAC cycle -> out_valid=0, busy=0, in_ready=1. Weights are cleared, so the next inference outputs (0,0).
